// File: rtl/md_pkg.sv
// -----------------------------------------------------------------------------
// md_pkg
// Shared definitions for the multiply/divide issue controller:
//   - md_op_t      : decoded HI/LO-class operation carried down the pipe
//   - MD_CTR_*     : op codes understood by the multiply/divide unit
//   - *_BUSY_DEF   : default Busy lengths of the unit after a Start
//   - helpers      : op classification and op -> MD_ctr translation
// -----------------------------------------------------------------------------
package md_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MFHI  = 4'd7,
        MD_MFLO  = 4'd8
    } md_op_t;

    localparam logic [2:0] MD_CTR_MULT  = 3'b000;
    localparam logic [2:0] MD_CTR_MULTU = 3'b001;
    localparam logic [2:0] MD_CTR_DIV   = 3'b010;
    localparam logic [2:0] MD_CTR_DIVU  = 3'b011;
    localparam logic [2:0] MD_CTR_MTHI  = 3'b100;
    localparam logic [2:0] MD_CTR_MTLO  = 3'b101;
    localparam logic [2:0] MD_CTR_NOP   = 3'b111;

    // Busy lengths must fit the 4-bit shadow counter.
    localparam logic [3:0] MULT_BUSY_DEF = 4'd4;
    localparam logic [3:0] DIV_BUSY_DEF  = 4'd9;

    // Ops that occupy the unit for several cycles and therefore need Start.
    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    // Reads (mfhi/mflo) and bubbles have no unit op: they map to NOP so the
    // unit never writes HI/LO on their behalf.
    function automatic logic [2:0] md_ctr_of(input logic [3:0] op);
        logic [2:0] ctr;
        case (op)
            MD_MULT:  ctr = MD_CTR_MULT;
            MD_MULTU: ctr = MD_CTR_MULTU;
            MD_DIV:   ctr = MD_CTR_DIV;
            MD_DIVU:  ctr = MD_CTR_DIVU;
            MD_MTHI:  ctr = MD_CTR_MTHI;
            MD_MTLO:  ctr = MD_CTR_MTLO;
            default:  ctr = MD_CTR_NOP;
        endcase
        return ctr;
    endfunction

endpackage

// File: rtl/md_shadow_cnt.sv
// -----------------------------------------------------------------------------
// md_shadow_cnt
// Shadow copy of the multiply/divide unit's busy timer plus a sticky check
// that the unit's Busy agrees with it.
//
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   start       : Start pulse as presented to the unit
//   is_div      : the started op is div/divu (selects the longer load)
//   lock        : unit frozen this cycle (interrupt/exception)
//   busy        : Busy output of the unit
//   cnt         : remaining busy cycles (0 = idle)
//   sync_err    : sticky, set when busy != (cnt != 0)
// -----------------------------------------------------------------------------
module md_shadow_cnt
    import md_pkg::*;
#(
    parameter logic [3:0] MULT_BUSY = MULT_BUSY_DEF,
    parameter logic [3:0] DIV_BUSY  = DIV_BUSY_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       is_div,
    input  logic       lock,
    input  logic       busy,
    output logic [3:0] cnt,
    output logic       sync_err
);

    // The first cycle after reset is not checked: the unit and this counter
    // leave reset on the same edge but the unit may take that cycle to settle.
    logic armed;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= 4'd0;
            armed    <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            armed <= 1'b1;

            // Busy rises the cycle after Start, so loading at the Start edge
            // makes cnt track Busy cycle for cycle. Lock freezes both.
            if (start && !lock) begin
                cnt <= is_div ? DIV_BUSY : MULT_BUSY;
            end else if ((cnt != 4'd0) && !lock) begin
                cnt <= cnt - 4'd1;
            end

            if (armed && (busy != (cnt != 4'd0))) begin
                sync_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/md_issue_ctrl.sv
// -----------------------------------------------------------------------------
// md_issue_ctrl
// E-stage issue and hazard controller in front of the multiply/divide unit.
// Holds the E-stage HI/LO-class op, drives Start/MD_ctr/lock_muldiv, stalls
// D while the unit is (or is about to be) busy, and cross-checks Busy against
// a shadow counter.
//
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   D_md_op      : decoded md op of the D-stage instruction (md_op_t)
//   D_stall_ext  : D stall from other hazard sources
//   E_flush      : insert a bubble into E
//   IntReq       : interrupt taken this cycle
//   ExcReq       : exception taken this cycle
//   Busy         : Busy from the multiply/divide unit
//   Start        : start pulse to the unit
//   MD_ctr       : unit op code (111 = no operation)
//   lock_muldiv  : freeze/kill to the unit
//   Stall_D      : total D-stage stall
//   E_md_op      : current E-stage op (HI/LO read mux select)
//   md_sync_err  : sticky Busy/shadow-counter disagreement
// -----------------------------------------------------------------------------
module md_issue_ctrl
    import md_pkg::*;
#(
    parameter logic [3:0] MULT_BUSY = MULT_BUSY_DEF,
    parameter logic [3:0] DIV_BUSY  = DIV_BUSY_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] D_md_op,
    input  logic       D_stall_ext,
    input  logic       E_flush,
    input  logic       IntReq,
    input  logic       ExcReq,
    input  logic       Busy,
    output logic       Start,
    output logic [2:0] MD_ctr,
    output logic       lock_muldiv,
    output logic       Stall_D,
    output logic [3:0] E_md_op,
    output logic       md_sync_err
);

    logic [3:0] e_op;
    logic       lock;
    logic       start_int;
    logic       md_hazard;
    logic       stall_int;
    logic [3:0] shadow_cnt;
    logic       sync_err_q;

    // The E register is only cleared at the reset edge, so during the reset
    // cycle it may still hold an in-flight op; every output is masked with
    // reset so nothing (in particular no Start) leaks out of that cycle.
    assign lock      = !reset && (IntReq || ExcReq);
    assign start_int = !reset && is_muldiv(e_op) && !lock;

    // Start is part of the hazard because Busy only rises the cycle after it.
    assign md_hazard = (D_md_op != MD_NONE) && (Busy || start_int);
    assign stall_int = !reset && (md_hazard || D_stall_ext);

    always_ff @(posedge clk) begin
        if (reset) begin
            e_op <= MD_NONE;
        end else if (IntReq || ExcReq || E_flush || stall_int) begin
            e_op <= MD_NONE;
        end else begin
            e_op <= D_md_op;
        end
    end

    // A squashed mthi/mtlo must not present 100/101: the unit writes HI/LO
    // for those codes without looking at Start.
    always_comb begin
        MD_ctr = MD_CTR_NOP;
        if (!reset && !lock) begin
            MD_ctr = md_ctr_of(e_op);
        end
    end

    md_shadow_cnt #(
        .MULT_BUSY (MULT_BUSY),
        .DIV_BUSY  (DIV_BUSY)
    ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .start    (start_int),
        .is_div   (is_div(e_op)),
        .lock     (lock),
        .busy     (Busy),
        .cnt      (shadow_cnt),
        .sync_err (sync_err_q)
    );

    assign Start       = start_int;
    assign lock_muldiv = lock;
    assign Stall_D     = stall_int;
    assign E_md_op     = reset ? MD_NONE : e_op;
    assign md_sync_err = !reset && sync_err_q;

endmodule

// File: tb/tb_md_issue_ctrl.sv
module tb_md_issue_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] d_op;
    logic       stall_ext, flush, irq, exc;
    logic       busy;
    logic       start, lock, stall_d, sync_err;
    logic [2:0] md_ctr;
    logic [3:0] e_op;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    md_issue_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .D_md_op     (d_op),
        .D_stall_ext (stall_ext),
        .E_flush     (flush),
        .IntReq      (irq),
        .ExcReq      (exc),
        .Busy        (busy),
        .Start       (start),
        .MD_ctr      (md_ctr),
        .lock_muldiv (lock),
        .Stall_D     (stall_d),
        .E_md_op     (e_op),
        .md_sync_err (sync_err)
    );

    // Stub of the multiply/divide unit: Busy for 4 (mult) or 9 (div) cycles
    // after an accepted Start, frozen by lock, cleared by reset.
    // busy_force: 0 = normal, 1 = hold Busy low, 2 = hold Busy high.
    int unit_rem = 0;
    int busy_force = 0;

    always @(posedge clk) begin
        if (reset)
            unit_rem <= 0;
        else if (start && !lock)
            unit_rem <= (md_ctr == 3'b010 || md_ctr == 3'b011) ? 9 : 4;
        else if (unit_rem > 0 && !lock)
            unit_rem <= unit_rem - 1;
    end

    assign busy = (busy_force == 2) ? 1'b1 :
                  (busy_force == 1) ? 1'b0 : (unit_rem != 0);

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One cycle: inputs change at negedge, outputs are sampled 1 ns later.
    task automatic step(input logic [3:0] d, input logic ext, input logic fl,
                        input logic ir, input logic ex);
        @(negedge clk);
        reset = 1'b0;
        d_op = d; stall_ext = ext; flush = fl; irq = ir; exc = ex;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        d_op = 4'd0; stall_ext = 1'b0; flush = 1'b0; irq = 1'b0; exc = 1'b0;
        busy_force = 0;
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_start"}, int'(start), 0);
        chk({tag, "_stall"}, int'(stall_d), 0);
        chk({tag, "_e"}, int'(e_op), 0);
        chk({tag, "_ctr"}, int'(md_ctr), 7);
        chk({tag, "_lock"}, int'(lock), 0);
        chk({tag, "_err"}, int'(sync_err), 0);
    endtask

    typedef struct {
        logic [3:0] d;
        logic       ext, fl, ir, ex;
        logic [3:0] x_e;
        logic       x_start;
        logic [2:0] x_ctr;
        logic       x_lock;
        logic       x_stall;
    } vec_t;

    vec_t tbl[10];

    // Reference model for the random phase: rules applied directly.
    int ctr_tab[9] = '{7, 0, 1, 2, 3, 4, 5, 7, 7};

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int m_e, x_start, x_lock, x_stall, x_ctr, busy_cycles;
        logic [3:0] rd;
        logic rext, rfl, rir, rex;

        reset = 1'b1;
        d_op = 4'd0; stall_ext = 1'b0; flush = 1'b0; irq = 1'b0; exc = 1'b0;

        //               d  ext fl ir ex   e  st ctr lk stl
        tbl[0] = '{4'd5, 0, 0, 0, 0, 4'd0, 0, 3'd7, 0, 0};
        tbl[1] = '{4'd6, 0, 0, 0, 0, 4'd5, 0, 3'd4, 0, 0};
        tbl[2] = '{4'd7, 0, 0, 0, 1, 4'd6, 0, 3'd7, 1, 0};
        tbl[3] = '{4'd8, 1, 0, 0, 0, 4'd0, 0, 3'd7, 0, 1};
        tbl[4] = '{4'd8, 0, 1, 0, 0, 4'd0, 0, 3'd7, 0, 0};
        tbl[5] = '{4'd6, 0, 0, 0, 0, 4'd0, 0, 3'd7, 0, 0};
        tbl[6] = '{4'd1, 0, 0, 1, 0, 4'd6, 0, 3'd7, 1, 0};
        tbl[7] = '{4'd4, 0, 0, 0, 0, 4'd0, 0, 3'd7, 0, 0};
        tbl[8] = '{4'd7, 0, 0, 0, 0, 4'd4, 1, 3'd3, 0, 1};
        tbl[9] = '{4'd7, 0, 0, 0, 0, 4'd0, 0, 3'd7, 0, 1};

        // Reset state, both during the reset cycle and just after.
        do_reset();
        chk_idle("rst");
        step(4'd0, 0, 0, 0, 0);
        chk_idle("post_rst");

        // Table-driven sequence.
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].d, tbl[i].ext, tbl[i].fl, tbl[i].ir, tbl[i].ex);
            chk($sformatf("tbl%0d_e", i), int'(e_op), int'(tbl[i].x_e));
            chk($sformatf("tbl%0d_start", i), int'(start), int'(tbl[i].x_start));
            chk($sformatf("tbl%0d_ctr", i), int'(md_ctr), int'(tbl[i].x_ctr));
            chk($sformatf("tbl%0d_lock", i), int'(lock), int'(tbl[i].x_lock));
            chk($sformatf("tbl%0d_stall", i), int'(stall_d), int'(tbl[i].x_stall));
        end
        chk("tbl_err", int'(sync_err), 0);

        // MULT issue with idle D afterwards.
        do_reset();
        step(4'd1, 0, 0, 0, 0);
        chk("mult_d_stall", int'(stall_d), 0);
        step(4'd0, 0, 0, 0, 0);
        chk("mult_e", int'(e_op), 1);
        chk("mult_start", int'(start), 1);
        chk("mult_ctr", int'(md_ctr), 0);
        for (int i = 0; i < 4; i++) begin
            step(4'd0, 0, 0, 0, 0);
            chk($sformatf("mult_cnt%0d", i), int'(dut.u_cnt.cnt), 4 - i);
            chk($sformatf("mult_nostart%0d", i), int'(start), 0);
        end
        step(4'd0, 0, 0, 0, 0);
        chk("mult_cnt_end", int'(dut.u_cnt.cnt), 0);
        chk("mult_err", int'(sync_err), 0);

        // MULT immediately followed by MFLO.
        do_reset();
        busy_cycles = 0;
        step(4'd1, 0, 0, 0, 0);
        chk("mflo_c0_stall", int'(stall_d), 0);
        for (int i = 0; i < 5; i++) begin
            step(4'd8, 0, 0, 0, 0);
            if (stall_d) busy_cycles++;
        end
        chk("mflo_stall_cycles", busy_cycles, 5);
        step(4'd8, 0, 0, 0, 0);
        chk("mflo_release", int'(stall_d), 0);
        step(4'd0, 0, 0, 0, 0);
        chk("mflo_in_e", int'(e_op), 8);

        // DIVU with a 2-cycle exception on Busy cycle 3.
        do_reset();
        step(4'd4, 0, 0, 0, 0);
        step(4'd0, 0, 0, 0, 0);
        chk("divu_start", int'(start), 1);
        chk("divu_ctr", int'(md_ctr), 3);
        busy_cycles = 0;
        step(4'd0, 0, 0, 0, 0);
        if (busy) busy_cycles++;
        step(4'd0, 0, 0, 0, 0);
        if (busy) busy_cycles++;
        step(4'd0, 0, 0, 0, 1);
        if (busy) busy_cycles++;
        chk("divu_lock1", int'(lock), 1);
        chk("divu_cnt_b3", int'(dut.u_cnt.cnt), 7);
        step(4'd0, 0, 0, 0, 1);
        if (busy) busy_cycles++;
        chk("divu_lock2", int'(lock), 1);
        chk("divu_cnt_b4", int'(dut.u_cnt.cnt), 7);
        step(4'd0, 0, 0, 0, 0);
        if (busy) busy_cycles++;
        chk("divu_unlock", int'(lock), 0);
        chk("divu_cnt_b5", int'(dut.u_cnt.cnt), 7);
        for (int i = 0; i < 30 && busy; i++) begin
            step(4'd0, 0, 0, 0, 0);
            if (busy) busy_cycles++;
        end
        chk("divu_busy_total", busy_cycles, 11);
        chk("divu_cnt_end", int'(dut.u_cnt.cnt), 0);
        chk("divu_err", int'(sync_err), 0);

        // MTHI in E squashed by an exception.
        do_reset();
        step(4'd5, 0, 0, 0, 0);
        step(4'd0, 0, 0, 0, 1);
        chk("mthi_exc_ctr", int'(md_ctr), 7);
        chk("mthi_exc_start", int'(start), 0);
        step(4'd0, 0, 0, 0, 0);
        chk("mthi_exc_e", int'(e_op), 0);
        chk("mthi_exc_ctr2", int'(md_ctr), 7);

        // DIV in E squashed by an interrupt, then a stuck-high Busy stub.
        do_reset();
        step(4'd3, 0, 0, 0, 0);
        step(4'd0, 0, 0, 1, 0);
        chk("div_irq_start", int'(start), 0);
        chk("div_irq_lock", int'(lock), 1);
        step(4'd0, 0, 0, 0, 0);
        chk("div_irq_cnt", int'(dut.u_cnt.cnt), 0);
        chk("div_irq_e", int'(e_op), 0);
        step(4'd0, 0, 0, 0, 0);
        chk("div_irq_noerr", int'(sync_err), 0);
        step(4'd0, 0, 0, 0, 0);
        busy_force = 2;
        chk("stub_err_before", int'(sync_err), 0);
        step(4'd0, 0, 0, 0, 0);
        busy_force = 0;
        chk("stub_err_set", int'(sync_err), 1);
        for (int i = 0; i < 3; i++) begin
            step(4'd0, 0, 0, 0, 0);
            chk($sformatf("stub_err_sticky%0d", i), int'(sync_err), 1);
        end
        do_reset();
        chk("stub_err_rst", int'(sync_err), 0);
        step(4'd0, 0, 0, 0, 0);
        chk("stub_err_after_rst", int'(sync_err), 0);

        // Reset on Busy cycle 2 of MULTU.
        do_reset();
        step(4'd2, 0, 0, 0, 0);
        step(4'd0, 0, 0, 0, 0);
        chk("multu_start", int'(start), 1);
        step(4'd0, 0, 0, 0, 0);
        do_reset();
        chk("multu_rst_start", int'(start), 0);
        step(4'd0, 0, 0, 0, 0);
        chk_idle("multu_after_rst");
        chk("multu_after_rst_cnt", int'(dut.u_cnt.cnt), 0);
        step(4'd0, 0, 0, 0, 0);
        chk("multu_after_rst_err", int'(sync_err), 0);

        // Randomized traffic against the reference model.
        do_reset();
        m_e = 0;
        for (int n = 0; n < 400; n++) begin
            rd   = 4'($urandom_range(0, 8));
            rext = ($urandom_range(0, 7) == 0);
            rfl  = ($urandom_range(0, 7) == 0);
            rir  = ($urandom_range(0, 15) == 0);
            rex  = ($urandom_range(0, 15) == 0);
            step(rd, rext, rfl, rir, rex);

            x_lock  = (rir || rex) ? 1 : 0;
            x_start = (m_e >= 1 && m_e <= 4 && x_lock == 0) ? 1 : 0;
            x_ctr   = x_lock ? 7 : ctr_tab[m_e];
            x_stall = ((rd != 0 && (busy || x_start == 1)) || rext) ? 1 : 0;

            chk("rnd_e", int'(e_op), m_e);
            chk("rnd_start", int'(start), x_start);
            chk("rnd_ctr", int'(md_ctr), x_ctr);
            chk("rnd_lock", int'(lock), x_lock);
            chk("rnd_stall", int'(stall_d), x_stall);
            chk("rnd_err", int'(sync_err), 0);

            m_e = (x_lock == 1 || rfl || x_stall == 1) ? 0 : int'(rd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/md_issue_ctrl.md
Name: md_issue_ctrl

Overview:
- E-stage issue and hazard controller sitting directly upstream of the multiply/divide unit.
- Holds the E-stage copy of the HI/LO-class operation and drives the unit's Start, MD_ctr and lock_muldiv inputs.
- Stalls the D stage while the unit is busy or about to become busy.
- Keeps a shadow busy counter and cross-checks it against the unit's Busy output to flag desynchronisation.

Parameters:
- MULT_BUSY, 4, cycles Busy stays high after a mult/multu Start.
- DIV_BUSY, 9, cycles Busy stays high after a div/divu Start.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- D_md_op  in  4  decoded HI/LO-class op of the D-stage instruction (md_op_t).
- D_stall_ext  in  1  D-stage stall raised by other hazard sources.
- E_flush  in  1  insert a bubble into E (branch-related).
- IntReq  in  1  interrupt taken this cycle.
- ExcReq  in  1  exception taken this cycle.
- Busy  in  1  Busy output of the multiply/divide unit.
- Start  out  1  start pulse to the unit.
- MD_ctr  out  3  unit op code.
- lock_muldiv  out  1  freeze/kill to the unit.
- Stall_D  out  1  total D-stage stall (md hazard OR D_stall_ext).
- E_md_op  out  4  current E-stage op, used by the HI/LO read mux.
- md_sync_err  out  1  sticky mismatch flag.

Behaviour:
- Reset: all outputs are 0, except MD_ctr=3'b111 and E_md_op=MD_NONE. E register = MD_NONE, shadow counter = 0, md_sync_err = 0. Reset mid-operation discards any in-flight op; no Start is emitted in the reset cycle.
- md_op_t encodings: MD_NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8.
- E register update, on each posedge with priority top-down:
  - reset: MD_NONE.
  - IntReq|ExcReq|E_flush|Stall_D: MD_NONE (bubble).
  - otherwise: D_md_op.
- lock_muldiv = IntReq | ExcReq. The instruction in E is being squashed, and the unit freezes its progress.
- Start = (E_md_op in MULT..DIVU) & !lock_muldiv. This is purely combinational from the E register.
- MD_ctr mapping:
  - MULT→000, MULTU→001, DIV→010, DIVU→011, MTHI→100, MTLO→101.
  - Every other op→111.
  - MD_ctr is also forced to 111 when lock_muldiv=1. The unit writes HI/LO for codes 100/101 regardless of Start, so a squashed mthi/mtlo must never present them.
- Hazard stall: md_hazard = (D_md_op != MD_NONE) & (Busy | Start). Start is included because Busy rises one cycle after Start. Stall_D = md_hazard | D_stall_ext.
- Issue latency:
  - A D-stage md op enters E on the first edge where Stall_D=0.
  - A mult/div starts (Start high) in the following cycle.
  - A back-to-back md op waits until the cycle Busy reads 0.
- Shadow counter (4 bits):
  - Start & !lock loads MULT_BUSY or DIV_BUSY.
  - Otherwise, when cnt != 0 and !lock, it decrements by 1.
  - Lock freezes it, mirroring the unit's freeze.
- Sync check, evaluated every cycle after the first post-reset cycle: if Busy != (cnt != 0), md_sync_err is set and stays set until reset.
- Simultaneous events:
  - IntReq/ExcReq together with Start: Start forced 0, counter not loaded, E becomes a bubble.
  - E_flush together with a stall: E becomes a bubble (same outcome either way).
  - Lock while Busy: the counter and Busy both hold; Stall_D stays high for any D md op.
- MFHI/MFLO in D also stall while busy, so reads always see final HI/LO.

Decomposition:
- Shared package md_pkg holds:
  - the md_op_t encodings;
  - the MD_ctr codes (000..101, and 111 as MD_CTR_NOP);
  - the MULT_BUSY/DIV_BUSY defaults.
- One sub-module, md_shadow_cnt, holds the counter and the sticky sync check. Hazard logic and the E register stay in the top.

Test Plan:
- MULT in D, D idle afterwards:
  - E=MULT the next cycle, Start=1 and MD_ctr=000 for one cycle.
  - Busy is high 4 cycles with cnt 4→3→2→1→0.
  - md_sync_err stays 0.
- MULT followed immediately by MFLO in D:
  - Stall_D=1 from the Start cycle through the last Busy cycle (5 cycles).
  - MFLO enters E the cycle after Busy falls.
- DIVU issued, ExcReq pulsed for 2 cycles on Busy cycle 3:
  - lock_muldiv=1 for 2 cycles and cnt holds at 7.
  - Busy totals 11 cycles.
  - No sync error.
- MTHI in E with ExcReq in the same cycle:
  - MD_ctr=111 and Start=0.
  - E=MD_NONE on the next edge, so HI is unchanged.
- DIV in E with IntReq the same cycle:
  - Start=0 and the counter stays 0.
  - A stubbed Busy of 0 gives no md_sync_err.
  - A stub holding Busy=1 sets md_sync_err=1, which stays sticky until reset.
- Reset asserted on Busy cycle 2 of MULTU (unit also reset):
  - The next cycle shows Start=0, Stall_D=0, E_md_op=MD_NONE, cnt=0 and md_sync_err=0.
